// File: rtl/filter_pkg.sv
// Shared definitions for the line-buffer filter front end: pad FSM encodings
// and the kernel-to-border width relation used by the pad and line FIFOs.
package filter_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PADROW = 3'd1,
        S_LEAD   = 3'd2,
        S_DATA   = 3'd3,
        S_TRAIL  = 3'd4,
        S_FLUSH  = 3'd5
    } pad_state_t;

    function automatic int boundary_width(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/filter_boundary_pad.sv
// Wraps each raster frame in a B-pixel zero border and appends flush zeros.
// Latency: accepted pixel appears on oData/oValid 1 cycle later (registered).
// Backpressure: iReady high only while streaming image pixels; no downstream stall.
module filter_boundary_pad
    import filter_pkg::*;
#(
    parameter int width        = 320,
    parameter int height       = 240,
    parameter int kernel_size  = 3,
    parameter int flush_pixels = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iValid,
    output logic        iReady,
    input  logic [23:0] iData,
    output logic        oValid,
    output logic [23:0] oData,
    output logic        oDone
);

    localparam int boundary_width_c = boundary_width(kernel_size);
    localparam int TW = width + 2 * boundary_width_c;
    localparam int TH = height + 2 * boundary_width_c;
    localparam int CW = $clog2(TW + 1);
    localparam int RW = $clog2(TH + 1);
    localparam int FW = (flush_pixels > 0) ? $clog2(flush_pixels + 1) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(TW - 1);
    localparam logic [CW-1:0] LEAD_LAST = CW'(boundary_width_c - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(boundary_width_c + width - 1);
    localparam logic [RW-1:0] ROW_TOP   = RW'(boundary_width_c);
    localparam logic [RW-1:0] ROW_IMG   = RW'(boundary_width_c + height);
    localparam logic [RW-1:0] ROW_ALL   = RW'(TH);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_pixels - 1);

    pad_state_t    state, state_nxt, eor_nxt, frame_end_nxt;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt, row_inc;
    logic [FW-1:0] flush_cnt;
    logic          accept, col_wrap, row_done, flush_last, emit_grid;

    always_comb begin
        iReady        = (state == S_DATA);
        accept        = iReady && iValid;
        col_wrap      = (col_cnt == COL_LAST);
        row_inc       = row_cnt + 1'b1;
        row_done      = (row_inc == ROW_ALL);
        flush_last    = (flush_cnt == FLUSH_LAST);
        emit_grid     = (state == S_PADROW) || (state == S_LEAD) ||
                        (state == S_TRAIL) || accept;
        frame_end_nxt = (flush_pixels > 0) ? S_FLUSH : S_IDLE;
        // End of an image row: more image rows, bottom border, or (B=0) frame end.
        if (row_inc == ROW_IMG)
            eor_nxt = (boundary_width_c > 0) ? S_PADROW : frame_end_nxt;
        else
            eor_nxt = (boundary_width_c > 0) ? S_LEAD : S_DATA;

        state_nxt = state;
        case (state)
            S_IDLE:   if (iValid) state_nxt = (boundary_width_c > 0) ? S_PADROW : S_DATA;
            S_PADROW: if (col_wrap) begin
                          if (row_inc == ROW_TOP)  state_nxt = S_LEAD;
                          else if (row_done)       state_nxt = frame_end_nxt;
                      end
            S_LEAD:   if (col_cnt == LEAD_LAST) state_nxt = S_DATA;
            S_DATA:   if (accept && (col_cnt == DATA_LAST))
                          state_nxt = (boundary_width_c > 0) ? S_TRAIL : eor_nxt;
            S_TRAIL:  if (col_wrap) state_nxt = eor_nxt;
            S_FLUSH:  if (flush_last) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            col_cnt   <= '0;
            row_cnt   <= '0;
            flush_cnt <= '0;
            oValid    <= 1'b0;
            oData     <= '0;
            oDone     <= 1'b0;
        end else begin
            state  <= state_nxt;
            oValid <= 1'b0;
            oData  <= '0;
            oDone  <= 1'b0;
            if (state == S_IDLE) begin
                col_cnt   <= '0;
                row_cnt   <= '0;
                flush_cnt <= '0;
            end
            // Every padded-grid pixel advances the column; the last column closes the row.
            if (emit_grid) begin
                oValid <= 1'b1;
                if (accept) oData <= iData;
                if (col_wrap) begin
                    col_cnt <= '0;
                    if (row_done) begin
                        row_cnt <= '0;
                        oDone   <= (flush_pixels == 0);
                    end else begin
                        row_cnt <= row_inc;
                    end
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
            if (state == S_FLUSH) begin
                oValid <= 1'b1;
                if (flush_last) begin
                    flush_cnt <= '0;
                    oDone     <= 1'b1;
                end else begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_boundary_pad.sv
// Directed bench for the pad stage: three configurations (k=3/flush, k=7, k=1)
// sharing one clock and reset; outputs captured per instance and checked in order.
module tb_filter_boundary_pad;

    logic        clk;
    logic        reset;
    logic        i_vld  [3];
    logic [23:0] i_dat  [3];
    logic        rdy    [3];
    logic        o_vld  [3];
    logic [23:0] o_dat  [3];
    logic        o_done [3];

    logic [23:0] out_q  [3][$];
    bit          done_q [3][$];
    int          cyc_q  [3][$];
    int          acc_q  [3][$];
    int          idx    [3];
    int          rdy_cnt[3];
    int          bubbles[3];
    int          cyc;
    int          checks;
    int          errors;

    filter_boundary_pad #(.width(4), .height(3), .kernel_size(3), .flush_pixels(2)) u_a (
        .clk(clk), .reset(reset), .iValid(i_vld[0]), .iReady(rdy[0]), .iData(i_dat[0]),
        .oValid(o_vld[0]), .oData(o_dat[0]), .oDone(o_done[0]));

    filter_boundary_pad #(.width(4), .height(2), .kernel_size(7), .flush_pixels(0)) u_b (
        .clk(clk), .reset(reset), .iValid(i_vld[1]), .iReady(rdy[1]), .iData(i_dat[1]),
        .oValid(o_vld[1]), .oData(o_dat[1]), .oDone(o_done[1]));

    filter_boundary_pad #(.width(2), .height(2), .kernel_size(1), .flush_pixels(0)) u_c (
        .clk(clk), .reset(reset), .iValid(i_vld[2]), .iReady(rdy[2]), .iData(i_dat[2]),
        .oValid(o_vld[2]), .oData(o_dat[2]), .oDone(o_done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (o_vld[d]) begin
                out_q[d].push_back(o_dat[d]);
                done_q[d].push_back(o_done[d]);
                cyc_q[d].push_back(cyc);
            end
            if (rdy[d]) rdy_cnt[d]++;
        end
    end

    function automatic logic [23:0] pix(input int n);
        return 24'hA50000 | 24'(n + 1);
    endfunction

    // Config A padded frame: 6x5 grid, image at rows 1..3 / cols 1..4, then 2 flush zeros.
    function automatic logic [23:0] exp_a(input int i);
        int r, c;
        if (i >= 30) return 24'h0;
        r = i / 6;
        c = i % 6;
        if (r == 0 || r == 4 || c == 0 || c == 5) return 24'h0;
        return pix((r - 1) * 4 + (c - 1));
    endfunction

    function automatic logic [23:0] qget(input int d, input int i);
        if (i < out_q[d].size()) return out_q[d][i];
        return 24'hxxxxxx;
    endfunction

    function automatic int done_at(input int d);
        for (int i = 0; i < done_q[d].size(); i++) if (done_q[d][i]) return i;
        return -1;
    endfunction

    function automatic int done_count(input int d);
        int n = 0;
        for (int i = 0; i < done_q[d].size(); i++) if (done_q[d][i]) n++;
        return n;
    endfunction

    function automatic int seq_errs_a(input int base);
        int n = 0;
        for (int i = 0; i < 32; i++) if (qget(0, base + i) !== exp_a(i)) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear(input int d);
        out_q[d].delete();
        done_q[d].delete();
        cyc_q[d].delete();
        acc_q[d].delete();
        idx[d]     = 0;
        rdy_cnt[d] = 0;
        bubbles[d] = 0;
    endtask

    task automatic drive(input int d, input int cycles, input bit toggle, input int limit, input int base);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            i_vld[d] = (idx[d] < limit) && (!toggle || (c % 2 == 0));
            i_dat[d] = pix(idx[d] % base);
            #4;
            if (i_vld[d] && rdy[d]) begin
                acc_q[d].push_back(cyc + 1);
                idx[d]++;
            end else if (rdy[d]) begin
                bubbles[d]++;
            end
        end
        @(negedge clk);
        i_vld[d] = 1'b0;
    endtask

    initial begin
        int zeros;
        checks = 0;
        errors = 0;
        for (int d = 0; d < 3; d++) begin
            i_vld[d] = 1'b0;
            i_dat[d] = 24'h0;
            clear(d);
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset oValid", 32'(o_vld[0]), 32'd0);
        chk("reset oData", 32'(o_dat[0]), 32'd0);
        chk("reset oDone", 32'(o_done[0]), 32'd0);
        chk("reset iReady", 32'(rdy[0]), 32'd0);
        @(negedge clk) reset = 1'b1;

        // T1: constant valid
        clear(0);
        drive(0, 45, 1'b0, 12, 12);
        chk("T1 count", out_q[0].size(), 32);
        chk("T1 out6", qget(0, 6), 24'h0);
        chk("T1 out7", qget(0, 7), pix(0));
        chk("T1 out10", qget(0, 10), pix(3));
        chk("T1 out11", qget(0, 11), 24'h0);
        chk("T1 out13", qget(0, 13), pix(4));
        chk("T1 seq errs", seq_errs_a(0), 0);
        chk("T1 done idx", done_at(0), 31);
        chk("T1 done cnt", done_count(0), 1);
        chk("T1 ready cycles", rdy_cnt[0], 12);
        chk("T1 latency", (cyc_q[0].size() > 7 && acc_q[0].size() > 0) ? cyc_q[0][7] - acc_q[0][0] : -1, 0);

        // T2: valid toggling 1/0
        clear(0);
        drive(0, 70, 1'b1, 12, 12);
        chk("T2 accepted", idx[0], 12);
        chk("T2 count", out_q[0].size(), 32);
        chk("T2 seq errs", seq_errs_a(0), 0);
        chk("T2 done idx", done_at(0), 31);
        chk("T2 gaps", (cyc_q[0].size() == 32) ? cyc_q[0][31] - cyc_q[0][0] + 1 - 32 : -1, bubbles[0]);
        chk("T2 latency px1", (cyc_q[0].size() > 8 && acc_q[0].size() > 1) ? cyc_q[0][8] - acc_q[0][1] : -1, 0);

        // T3: k=7, 10x8 grid
        clear(1);
        drive(1, 100, 1'b0, 8, 8);
        zeros = 0;
        for (int i = 0; i < 33; i++) if (qget(1, i) === 24'h0) zeros++;
        chk("T3 count", out_q[1].size(), 80);
        chk("T3 lead zeros", zeros, 33);
        chk("T3 out33", qget(1, 33), pix(0));
        chk("T3 out36", qget(1, 36), pix(3));
        chk("T3 out37", qget(1, 37), 24'h0);
        chk("T3 out43", qget(1, 43), pix(4));
        chk("T3 done idx", done_at(1), 79);
        chk("T3 done cnt", done_count(1), 1);

        // T4: k=1, passthrough
        clear(2);
        drive(2, 20, 1'b0, 4, 4);
        chk("T4 count", out_q[2].size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("T4 out%0d", i), qget(2, i), pix(i));
        chk("T4 done idx", done_at(2), 3);

        // T5: reset mid-row while streaming
        clear(0);
        drive(0, 10, 1'b0, 12, 12);
        chk("T5 pre accepted", idx[0], 2);
        i_vld[0] = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("T5 async oValid", 32'(o_vld[0]), 32'd0);
        chk("T5 async oData", 32'(o_dat[0]), 32'd0);
        chk("T5 async iReady", 32'(rdy[0]), 32'd0);
        i_vld[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        clear(0);
        drive(0, 45, 1'b0, 12, 12);
        zeros = 0;
        for (int i = 0; i < 7; i++) if (qget(0, i) === 24'h0) zeros++;
        chk("T5 top zeros", zeros, 7);
        chk("T5 out7", qget(0, 7), pix(0));
        chk("T5 seq errs", seq_errs_a(0), 0);
        chk("T5 done idx", done_at(0), 31);

        // T6: back-to-back frames
        clear(0);
        drive(0, 90, 1'b0, 24, 12);
        chk("T6 count", out_q[0].size(), 64);
        chk("T6 done cnt", done_count(0), 2);
        chk("T6 done last", (done_q[0].size() == 64) ? 32'(done_q[0][63]) : 32'hFFFF, 32'd1);
        chk("T6 gap le2", (cyc_q[0].size() > 32) ? 32'((cyc_q[0][32] - cyc_q[0][31]) <= 2) : 32'd0, 32'd1);
        chk("T6 f1 seq errs", seq_errs_a(0), 0);
        chk("T6 f2 seq errs", seq_errs_a(32), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
